// File: rtl/seg_mux_display_if.sv
// User-side bus of the multiplexed seven-segment driver: buffered display
// data and controls in, registered segment/digit pins and frame pulse out.
interface seg_mux_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic                    enable;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  // user logic / stimulus side
  modport master (
    output value, dp_in, load, blank_lz, enable,
    input  seg, dp, digit_en, frame_done
  );

  // display driver side
  modport slave (
    input  value, dp_in, load, blank_lz, enable,
    output seg, dp, digit_en, frame_done
  );
endinterface

// File: rtl/seg_mux_display.sv
// Time-multiplexed seven-segment driver: one digit per refresh slot with a
// dark guard window at slot start, leading-zero blanking, per-digit decimal
// points and a double buffer that only swaps at the start of a frame.

// Per-digit decode: hex nibble to active-high segment pattern, with optional
// blanking of both segments and decimal point.
module seg_digit_lane (
  input  logic [3:0] nib,
  input  logic       dp_bit,
  input  logic       blank,
  output logic [6:0] seg_ah,
  output logic       dp_ah
);
  logic [6:0] pat;

  // hex to g..a pattern, full 0-F
  always_comb begin
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  assign seg_ah = blank ? 7'h00 : pat;
  assign dp_ah  = dp_bit & ~blank;
endmodule

module seg_mux_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int GUARD          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_mux_display_if.slave  bus
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val, eff_val;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, eff_dp;
  logic                    pend_flag;
  logic                    frame_start, apply;

  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS-1:0]      lane_dp;
  logic [NUM_DIGITS:1]        zc;     // zc[i]: digits N-1..i are 0 with no dp

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic                  fd_q;

  // The swap edge is the first cycle of digit 0's slot. Decoding looks
  // through to the pending buffer on that cycle so even a zero-length guard
  // never shows the old frame's digit 0 after the swap.
  assign frame_start = bus.enable & (presc == '0) & (idx == '0);
  assign apply       = frame_start & pend_flag;
  assign eff_val     = apply ? pend_val : act_val;
  assign eff_dp      = apply ? pend_dp  : act_dp;

  assign zc[NUM_DIGITS] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    logic blank;
    if (g == 0) begin : g_lsd
      assign blank = 1'b0;   // the units digit always shows
    end else begin : g_upper
      assign zc[g] = zc[g+1] & (eff_val[4*g +: 4] == 4'h0) & ~eff_dp[g];
      assign blank = bus.blank_lz & zc[g];
    end
    seg_digit_lane u_lane (
      .nib    (eff_val[4*g +: 4]),
      .dp_bit (eff_dp[g]),
      .blank  (blank),
      .seg_ah (lane_seg[g]),
      .dp_ah  (lane_dp[g])
    );
  end

  // slot prescaler and digit index; parked at 0 while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!bus.enable) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == P_LAST) begin
      presc <= '0;
      idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // double buffer: a load coinciding with the swap re-arms pending, so the
  // swap takes the older contents and the new load waits a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else begin
      if (apply) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end
      if (bus.load) begin
        pend_val  <= bus.value;
        pend_dp   <= bus.dp_in;
        pend_flag <= 1'b1;
      end
    end
  end

  // registered pin drive: dark while disabled or inside the guard window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {7{SEG_INV}};
      dp_q  <= SEG_INV;
      en_q  <= {NUM_DIGITS{DIG_INV}};
      fd_q  <= 1'b0;
    end else begin
      if (!bus.enable || (presc < P_GUARD)) begin
        seg_q <= {7{SEG_INV}};
        dp_q  <= SEG_INV;
        en_q  <= {NUM_DIGITS{DIG_INV}};
      end else begin
        seg_q <= lane_seg[idx] ^ {7{SEG_INV}};
        dp_q  <= lane_dp[idx] ^ SEG_INV;
        en_q  <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{DIG_INV}};
      end
      fd_q <= bus.enable & (presc == P_LAST) & (idx == I_LAST);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display (4 digits, 8-cycle slots, 2-cycle guard).
// A frame-level reference model predicts every output cycle from elapsed
// scan time and the load history; scenario tasks add directed checks.
module tb_seg_mux_display;
  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int G   = 2;
  localparam logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg_mux_display_if #(.NUM_DIGITS(N)) bus ();

  seg_mux_display #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(G),
                    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // reference model: scan time since enable, pending/active frames
  int         mt;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pd, m_ad;
  logic        m_pf;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [3:0]  exp_en;

  always @(posedge clk or negedge rst_n) begin
    int p, d;
    logic fs, sup;
    logic [15:0] ev;
    logic [3:0] ed, nib;
    if (!rst_n) begin
      mt <= 0; m_pv <= '0; m_av <= '0; m_pd <= '0; m_ad <= '0; m_pf <= 1'b0;
      exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_en <= 4'hF; exp_fd <= 1'b0;
    end else begin
      if (bus.enable) begin
        p  = mt % DIV;
        d  = (mt / DIV) % N;
        fs = (mt % (DIV * N)) == 0;
        ev = (fs && m_pf) ? m_pv : m_av;
        ed = (fs && m_pf) ? m_pd : m_ad;
        if (p < G) begin
          exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_en <= 4'hF;
        end else begin
          nib = ev[4*d +: 4];
          sup = bus.blank_lz && (d > 0) && ((ev >> (4*d)) == 0) && ((ed >> d) == 0);
          exp_seg <= sup ? 7'h7F : ~SEGTAB[nib];
          exp_dp  <= sup ? 1'b1 : ~ed[d];
          exp_en  <= ~(4'b0001 << d);
        end
        exp_fd <= (p == DIV - 1) && (d == N - 1);
        mt <= mt + 1;
        if (fs && m_pf) begin
          m_av <= m_pv; m_ad <= m_pd; m_pf <= 1'b0;
        end
      end else begin
        exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_en <= 4'hF; exp_fd <= 1'b0;
        mt <= 0;
      end
      if (bus.load) begin
        m_pv <= bus.value; m_pd <= bus.dp_in; m_pf <= 1'b1;
      end
    end
  end

  // returns on the sample where frame_done is high (scan state at frame start)
  task automatic sync_frame(input string tag);
    bit hit = 0;
    for (int k = 0; k < 4 * N * DIV && !hit; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) hit = 1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s_sync: frame_done not seen, required within %0d cycles", tag, 4 * N * DIV);
    end
  endtask

  task automatic test_reset();
    int k = 0;
    rst_n = 1'b0; bus.value = '0; bus.dp_in = '0; bus.load = 1'b0;
    bus.blank_lz = 1'b0; bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got %h required %h",
               {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (k == 0 && bus.digit_en === 4'hE) k = i;
      n_cmp++;
      if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
        n_bad++;
        $display("FAIL reset_scan: got %h required %h",
                 {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
      end
    end
    n_cmp++;
    if (k != G + 1) begin
      n_bad++;
      $display("FAIL reset_first_digit: got cycle %0d required %0d", k, G + 1);
    end
    // asynchronous assertion between clock edges
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got %h required %h",
               {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int fds = 0, d0 = 0, d3 = 0;
    bus.value = 16'h12AF; bus.dp_in = 4'h0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    sync_frame("scan");
    for (int s = 1; s <= 2 * N * DIV; s++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) fds++;
      if (bus.digit_en === 4'hE && bus.seg === 7'h0E) d0++;
      if (bus.digit_en === 4'h7 && bus.seg === 7'h79) d3++;
      n_cmp++;
      if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
        n_bad++;
        $display("FAIL scan_cycle: got %h required %h",
                 {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
      end
    end
    n_cmp++;
    if (fds != 2) begin n_bad++; $display("FAIL scan_frame_done: got %0d pulses required 2", fds); end
    n_cmp++;
    if (d0 != 2 * (DIV - G)) begin n_bad++; $display("FAIL scan_digit0_F: got %0d cycles required %0d", d0, 2 * (DIV - G)); end
    n_cmp++;
    if (d3 != 2 * (DIV - G)) begin n_bad++; $display("FAIL scan_digit3_1: got %0d cycles required %0d", d3, 2 * (DIV - G)); end
  endtask

  task automatic test_tear();
    int bad_a = 0, bad_b = 0;
    // phase 1: 1111 live, then two loads during digit 2's slot
    repeat (2) @(negedge clk);
    bus.value = 16'h1111; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    sync_frame("tear");
    for (int s = 1; s <= 2 * N * DIV; s++) begin
      @(negedge clk);
      if (bus.digit_en !== 4'hF) begin
        if (s <= N * DIV && bus.seg !== 7'h79) bad_a++;
        if (s >  N * DIV && bus.seg !== 7'h24) bad_b++;
      end
      n_cmp++;
      if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
        n_bad++;
        $display("FAIL tear_cycle: got %h required %h",
                 {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
      end
      if (s == 2 * DIV + 2) begin bus.value = 16'($urandom); bus.load = 1'b1; end
      if (s == 2 * DIV + 3) bus.value = 16'h2222;
      if (s == 2 * DIV + 4) bus.load = 1'b0;
    end
    n_cmp++;
    if (bad_a != 0) begin n_bad++; $display("FAIL tear_old_frame: got %0d torn cycles required 0", bad_a); end
    n_cmp++;
    if (bad_b != 0) begin n_bad++; $display("FAIL tear_new_frame: got %0d stale cycles required 0", bad_b); end
    // phase 2: 5555 pending, 4444 loaded on the swap cycle itself
    repeat (3) @(negedge clk);
    bus.value = 16'h5555; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    sync_frame("coinc");
    bus.value = 16'h4444; bus.load = 1'b1;
    bad_a = 0; bad_b = 0;
    for (int s = 1; s <= 2 * N * DIV; s++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (bus.digit_en !== 4'hF) begin
        if (s <= N * DIV && bus.seg !== 7'h12) bad_a++;
        if (s >  N * DIV && bus.seg !== 7'h19) bad_b++;
      end
      n_cmp++;
      if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
        n_bad++;
        $display("FAIL coinc_cycle: got %h required %h",
                 {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
      end
    end
    n_cmp++;
    if (bad_a != 0) begin n_bad++; $display("FAIL coinc_first_frame: got %0d cycles not 5 required 0", bad_a); end
    n_cmp++;
    if (bad_b != 0) begin n_bad++; $display("FAIL coinc_deferred: got %0d cycles not 4 required 0", bad_b); end
  endtask

  task automatic test_lz();
    logic [15:0] vals [6];
    logic [3:0]  dps  [6];
    int          lit_req [6];
    int          lit;
    vals = '{16'h0050, 16'h0000, 16'h0005, 16'h0, 16'h0, 16'h0};
    dps  = '{4'b0000, 4'b0000, 4'b0100, 4'h0, 4'h0, 4'h0};
    lit_req = '{2 * (DIV - G), DIV - G, 3 * (DIV - G), -1, -1, -1};
    for (int c = 3; c < 6; c++) begin
      vals[c] = 16'($urandom) >> $urandom_range(0, 15);
      dps[c]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    end
    bus.blank_lz = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.value = vals[c]; bus.dp_in = dps[c]; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      sync_frame("lz");
      lit = 0;
      for (int s = 1; s <= N * DIV; s++) begin
        @(negedge clk);
        if (bus.seg !== 7'h7F) lit++;
        n_cmp++;
        if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
          n_bad++;
          $display("FAIL lz_cycle: case %0d got %h required %h", c,
                   {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
        end
      end
      if (lit_req[c] >= 0) begin
        n_cmp++;
        if (lit != lit_req[c]) begin
          n_bad++;
          $display("FAIL lz_lit_count: case %0d got %0d required %0d", c, lit, lit_req[c]);
        end
      end
    end
    bus.blank_lz = 1'b0;
    bus.dp_in = 4'h0;
  endtask

  task automatic test_enable();
    int k = 0;
    logic [3:0] dpr;
    sync_frame("en");
    repeat (DIV + 3) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL enable_off: got %h required %h",
               {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    bus.value = 16'h0E0E; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (k == 0 && bus.digit_en === 4'hE) k = i;
      n_cmp++;
      if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
        n_bad++;
        $display("FAIL enable_restart: got %h required %h",
                 {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
      end
    end
    n_cmp++;
    if (k != G + 1) begin n_bad++; $display("FAIL enable_first_digit: got cycle %0d required %0d", k, G + 1); end
    // decode sweep on digit 0
    for (int h = 0; h < 16; h++) begin
      dpr = 4'($urandom);
      bus.value = {12'($urandom), 4'(h)}; bus.dp_in = dpr; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      sync_frame("sweep");
      repeat (G + 1) @(negedge clk);
      n_cmp++;
      if ({bus.digit_en, bus.seg, bus.dp} !== {4'hE, ~SEGTAB[h], ~dpr[0]}) begin
        n_bad++;
        $display("FAIL decode_%0h: got en=%h seg=%h dp=%b required en=e seg=%h dp=%b",
                 h, bus.digit_en, bus.seg, bus.dp, ~SEGTAB[h], ~dpr[0]);
      end
    end
    bus.dp_in = 4'h0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.seg, bus.dp, bus.digit_en, bus.frame_done} !== {exp_seg, exp_dp, exp_en, exp_fd}) begin
        n_bad++;
        $display("FAIL random_cycle %0d: got %h required %h", i,
                 {bus.seg, bus.dp, bus.digit_en, bus.frame_done}, {exp_seg, exp_dp, exp_en, exp_fd});
      end
      bus.load = ($urandom_range(0, 5) == 0);
      bus.value = 16'($urandom) >> $urandom_range(0, 15);
      bus.dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 39) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
    end
    bus.load = 1'b0;
    bus.enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_lz();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
